// File: rtl/button_pulse_conditioner.sv
// Two-channel push-button conditioner: 2-flop synchroniser, debounce FSM and a one-clock
// active-low press pulse per channel. Define AUTO_REPEAT_EN to emit repeat pulses while held.
module button_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up_n,
   input  logic btn_down_n,
   output logic up,
   output logic down,
   output logic conflict,
   output logic up_held,
   output logic down_held
);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_e;

   localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || CNT_W < 2) begin : g_bad_params
      $error("button_pulse_conditioner: illegal parameter combination");
   end

   // Index 0 is the up channel, index 1 the down channel.
   logic [1:0]       s1_q, s1_d, s2_q, s2_d;
   state_e           state_q [2];
   state_e           state_d [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       req;
   logic             up_q, up_d, down_q, down_d, conflict_q, conflict_d;
`ifdef AUTO_REPEAT_EN
   logic [CNT_W-1:0] rep_q [2];
   logic [CNT_W-1:0] rep_d [2];
   localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_comb begin
      s1_d = {btn_down_n, btn_up_n};
      s2_d = s1_q;
      req  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef AUTO_REPEAT_EN
         rep_d[i]   = rep_q[i];
`endif
         case (state_q[i])
            IDLE: begin
               if (!s2_q[i]) begin
                  state_d[i] = PRESS_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end else begin
                  cnt_d[i] = '0;
               end
            end
            PRESS_WAIT: begin
               if (s2_q[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == D_LAST) begin
                  state_d[i] = HELD;
                  cnt_d[i]   = '0;
                  req[i]     = 1'b1;
`ifdef AUTO_REPEAT_EN
                  rep_d[i]   = '0;
`endif
               end else begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
               end
            end
            HELD: begin
               if (s2_q[i]) begin
                  state_d[i] = REL_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end
`ifdef AUTO_REPEAT_EN
               else if (rep_q[i] == R_LAST) begin
                  req[i]   = 1'b1;
                  rep_d[i] = '0;
               end else begin
                  rep_d[i] = sat_inc(rep_q[i]);
               end
`endif
            end
            REL_WAIT: begin
               // A low sample here is a release bounce: back to HELD without a pulse.
               if (!s2_q[i]) begin
                  state_d[i] = HELD;
                  cnt_d[i]   = '0;
`ifdef AUTO_REPEAT_EN
                  rep_d[i]   = '0;
`endif
               end else if (cnt_q[i] == D_LAST) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
      // Coinciding requests are suppressed on both outputs and flagged instead.
      conflict_d = req[0] & req[1];
      up_d       = ~(req[0] & ~req[1]);
      down_d     = ~(req[1] & ~req[0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 2'b11;
         s2_q       <= 2'b11;
         up_q       <= 1'b1;
         down_q     <= 1'b1;
         conflict_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
`ifdef AUTO_REPEAT_EN
            rep_q[i]   <= '0;
`endif
         end
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         up_q       <= up_d;
         down_q     <= down_d;
         conflict_q <= conflict_d;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
`ifdef AUTO_REPEAT_EN
            rep_q[i]   <= rep_d[i];
`endif
         end
      end
   end

   assign up        = up_q;
   assign down      = down_q;
   assign conflict  = conflict_q;
   assign up_held   = (state_q[0] == HELD) || (state_q[0] == REL_WAIT);
   assign down_held = (state_q[1] == HELD) || (state_q[1] == REL_WAIT);

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner (D=4, R=8): per-cycle expected output vectors
// {up, down, conflict, up_held, down_held} are queued with the stimulus and checked each clock.
module tb_button_pulse_conditioner;

   localparam logic [4:0] IDL   = 5'b11000;
   localparam logic [4:0] PUP   = 5'b01010;
   localparam logic [4:0] HUP   = 5'b11010;
   localparam logic [4:0] CONF  = 5'b11111;
   localparam logic [4:0] HBOTH = 5'b11011;

   logic clk = 1'b0;
   logic reset, btn_up_n, btn_down_n;
   logic up, down, conflict, up_held, down_held;

   logic [4:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   button_pulse_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_CYCLES  (8),
      .CNT_W          (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_up_n  (btn_up_n),
      .btn_down_n(btn_down_n),
      .up        (up),
      .down      (down),
      .conflict  (conflict),
      .up_held   (up_held),
      .down_held (down_held)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b ({up,down,conflict,up_held,down_held})",
                  tag, got, exp);
      end
   endtask

   task automatic push(input int n, input logic [4:0] v);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   // Apply one clock of stimulus, then compare the outputs 1 time unit after the edge.
   task automatic step(input logic r, input logic bu, input logic bd, input string tag);
      logic [4:0] e;
      reset      = r;
      btn_up_n   = bu;
      btn_down_n = bd;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no expected vector queued", tag);
      end else begin
         e = exp_q.pop_front();
         check_vec(tag, {up, down, conflict, up_held, down_held}, e);
      end
   endtask

   task automatic idle_gap(input int n);
      push(n, IDL);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, "idle_gap");
   endtask

   initial begin
      reset      = 1'b1;
      btn_up_n   = 1'b1;
      btn_down_n = 1'b1;

      // 1: reset with buttons released
      push(2, IDL);
      step(1'b1, 1'b1, 1'b1, "reset");
      step(1'b1, 1'b1, 1'b1, "reset");
      idle_gap(4);

      // 2: up held 22 clocks, then released
      for (int k = 0; k < 30; k++) begin
         logic [4:0] v;
         v = (k < 5) ? IDL : (k == 5) ? PUP : (k <= 26) ? HUP : IDL;
`ifdef AUTO_REPEAT_EN
         if (k == 13 || k == 21) v = PUP;
`endif
         exp_q.push_back(v);
      end
      for (int k = 0; k < 30; k++) step(1'b0, (k < 22) ? 1'b0 : 1'b1, 1'b1, "up_hold");
      idle_gap(3);

      // 3: three-clock glitch is one short of qualifying
      push(12, IDL);
      for (int k = 0; k < 12; k++) step(1'b0, (k < 3) ? 1'b0 : 1'b1, 1'b1, "glitch");

      // 4: release bounce keeps HELD, full release then re-press gives a second pulse
      for (int k = 0; k < 39; k++) begin
         logic [4:0] v;
         if (k < 5) v = IDL;
         else if (k == 5) v = PUP;
         else if (k <= 24) v = HUP;
         else if (k <= 30) v = IDL;
         else if (k == 31) v = PUP;
         else if (k <= 36) v = HUP;
         else v = IDL;
         exp_q.push_back(v);
      end
      for (int k = 0; k < 39; k++) begin
         logic bu;
         bu = ((k >= 10 && k < 12) || (k >= 20 && k < 26) || k >= 32) ? 1'b1 : 1'b0;
         step(1'b0, bu, 1'b1, "bounce");
      end
      idle_gap(3);

      // 5: both pressed on the same edge
      for (int k = 0; k < 15; k++)
         exp_q.push_back((k < 5) ? IDL : (k == 5) ? CONF : (k <= 12) ? HBOTH : IDL);
      for (int k = 0; k < 15; k++)
         step(1'b0, (k < 8) ? 1'b0 : 1'b1, (k < 8) ? 1'b0 : 1'b1, "conflict");
      idle_gap(3);

      // 6: reset at E3 of a press; button stays low and must re-qualify
      for (int k = 0; k < 20; k++)
         exp_q.push_back((k < 9) ? IDL : (k == 9) ? PUP : (k <= 17) ? HUP : IDL);
      for (int k = 0; k < 20; k++)
         step((k == 3) ? 1'b1 : 1'b0, (k < 13) ? 1'b0 : 1'b1, 1'b1, "reset_mid");

      // 7: random idle-level noise on one button never longer than 3 clocks low
      for (int n = 0; n < 5; n++) begin
         int len;
         len = $urandom_range(1, 3);
         push(len + 6, IDL);
         for (int k = 0; k < len + 6; k++)
            step(1'b0, 1'b1, (k < len) ? 1'b0 : 1'b1, "rand_glitch");
      end

      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL leftover: %0d expected vectors never compared, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
